// File: rtl/cpu_1_oci_dct_packer.sv
// rtl/cpu_1_oci_dct_packer.sv - packs 2-bit conditional-branch trace codes into frames for the trace FIFO
module cpu_1_oci_dct_packer #(
    parameter int DCT_ENTRIES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trace_en,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    output logic        dct_ready,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [33:0] frm_data
);

    localparam logic [3:0] MAX_COUNT = 4'(DCT_ENTRIES);

    logic        flush_pend;
    logic        full;
    logic        slot_free;
    logic        accept;
    logic        emit;
    logic [29:0] buf_nxt;
    logic [3:0]  cnt_nxt;
    logic        pend_nxt;

    assign full      = (dct_count == MAX_COUNT);
    assign slot_free = !frm_valid || frm_ready;
    assign dct_ready = !full || slot_free;
    assign accept    = dct_valid && dct_ready && trace_en && (dct_code != 2'b00);
    assign emit      = slot_free && (full || (flush_pend && (dct_count != 4'd0)));

    // Unused slots are always zero, so a new code can simply be OR-ed into place.
    always_comb begin
        buf_nxt = dct_buffer;
        cnt_nxt = dct_count;
        if (emit) begin
            buf_nxt = '0;
            cnt_nxt = '0;
            if (accept) begin
                buf_nxt[1:0] = dct_code;
                cnt_nxt      = 4'd1;
            end
        end else if (accept) begin
            buf_nxt = dct_buffer | (30'(dct_code) << {dct_count, 1'b0});
            cnt_nxt = dct_count + 4'd1;
        end
    end

    // A new flush request wins over any clearing condition in the same cycle.
    always_comb begin
        pend_nxt = flush_pend;
        if (flush) begin
            pend_nxt = 1'b1;
        end else if (emit || ((dct_count == 4'd0) && !accept)) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            flush_pend <= 1'b0;
        end else begin
            dct_buffer <= buf_nxt;
            dct_count  <= cnt_nxt;
            flush_pend <= pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_valid <= 1'b0;
            frm_data  <= '0;
        end else if (emit) begin
            frm_valid <= 1'b1;
            frm_data  <= {dct_count, dct_buffer};
        end else if (frm_valid && frm_ready) begin
            frm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_1_oci_dct_packer.sv
// tb/tb_cpu_1_oci_dct_packer.sv - self-checking bench for cpu_1_oci_dct_packer
module tb_cpu_1_oci_dct_packer;

    localparam int N = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        dct_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic        frm_ready;
    logic [33:0] frm_data;

    cpu_1_oci_dct_packer #(.DCT_ENTRIES(N)) dut (
        .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .dct_valid(dct_valid),
        .dct_code(dct_code), .dct_ready(dct_ready), .flush(flush),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .frm_valid(frm_valid),
        .frm_ready(frm_ready), .frm_data(frm_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int hs     = 0;

    // Model: the buffer is a queue of codes, the frame slot a second queue.
    int q[$];
    int fq[$];
    bit m_fv;
    bit m_pend;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fq.delete();
        m_fv   = 1'b0;
        m_pend = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            bit is_full, slot, rdy, acc, em;
            if (frm_valid && frm_ready) hs++;
            is_full = (q.size() == N);
            slot    = !m_fv || frm_ready;
            rdy     = !is_full || slot;
            acc     = dct_valid && rdy && trace_en && (dct_code != 2'b00);
            em      = slot && (is_full || (m_pend && q.size() > 0));
            if (flush) m_pend = 1'b1;
            else if (em || (q.size() == 0 && !acc)) m_pend = 1'b0;
            if (em) begin
                fq   = q;
                m_fv = 1'b1;
                q.delete();
            end else if (m_fv && frm_ready) begin
                m_fv = 1'b0;
            end
            if (acc) q.push_back(int'(dct_code));
        end
    end

    initial begin
        forever begin
            logic [29:0] eb;
            logic [29:0] fb;
            @(negedge clk);
            if (!reset_n) model_reset();
            eb = '0;
            fb = '0;
            foreach (q[k])  eb = eb + (30'(q[k])  << (2 * k));
            foreach (fq[k]) fb = fb + (30'(fq[k]) << (2 * k));
            chk("dct_count",  34'(dct_count),  34'(q.size()));
            chk("dct_buffer", 34'(dct_buffer), 34'(eb));
            chk("dct_ready",  34'(dct_ready),  34'(q.size() < N || !m_fv || frm_ready));
            chk("frm_valid",  34'(frm_valid),  34'(m_fv));
            if (m_fv) chk("frm_data", frm_data, {4'(fq.size()), fb});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] c);
        dct_valid = 1'b1;
        dct_code  = c;
        step(1);
        dct_valid = 1'b0;
        dct_code  = 2'b00;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        int hs0;
        reset_n   = 1'b0;
        trace_en  = 1'b1;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
        frm_ready = 1'b1;
        step(3);
        chk("reset_count", 34'(dct_count), 34'd0);
        chk("reset_frm_valid", 34'(frm_valid), 34'd0);
        chk("reset_ready", 34'(dct_ready), 34'd1);
        reset_n = 1'b1;
        step(2);

        // 1: full frame of 01,10,11,...
        for (int i = 0; i < N; i++) send(2'((i % 3) + 1));
        step(1);
        chk("t1_frm_valid", 34'(frm_valid), 34'd1);
        chk("t1_frm_count", 34'(frm_data[33:30]), 34'd15);
        chk("t1_frm_low", 34'(frm_data[5:0]), 34'h39);
        chk("t1_count_cleared", 34'(dct_count), 34'd0);
        step(1);
        chk("t1_frm_gone", 34'(frm_valid), 34'd0);

        // 2: partial flush, then flush of empty buffer
        send(2'b01); send(2'b01); send(2'b10);
        hs0 = hs;
        pulse_flush();
        step(1);
        chk("t2_frm_data", frm_data, {4'd3, 30'h0000_0025});
        step(2);
        chk("t2_one_frame", 34'(hs - hs0), 34'd1);
        pulse_flush();
        step(3);
        chk("t2_empty_flush", 34'(hs - hs0), 34'd1);
        chk("t2_no_valid", 34'(frm_valid), 34'd0);

        // 3: backpressure fills frame slot and buffer
        frm_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(2'((i % 3) + 1));
        step(2);
        chk("t3_ready_low", 34'(dct_ready), 34'd0);
        chk("t3_count_hold", 34'(dct_count), 34'd15);
        chk("t3_frm_held", 34'(frm_valid), 34'd1);
        frm_ready = 1'b1;
        #1;
        chk("t3_ready_comb", 34'(dct_ready), 34'd1);
        step(1);
        chk("t3_frame2_loaded", 34'(frm_valid), 34'd1);
        chk("t3_frame2_count", 34'(frm_data[33:30]), 34'd15);
        step(3);

        // 4: accept on the full-emit cycle
        for (int i = 0; i <= N; i++) send((i == N) ? 2'b11 : 2'b01);
        chk("t4_frm_count", 34'(frm_data[33:30]), 34'd15);
        chk("t4_new_count", 34'(dct_count), 34'd1);
        chk("t4_new_code", 34'(dct_buffer), 34'd3);
        pulse_flush();
        step(3);

        // 5: reserved codes and disabled trace are dropped
        chk("t5_start", 34'(dct_count), 34'd0);
        send(2'b01);
        send(2'b00);
        trace_en = 1'b0; send(2'b10); trace_en = 1'b1;
        send(2'b11);
        send(2'b00);
        trace_en = 1'b0; send(2'b01);
        chk("t5_count", 34'(dct_count), 34'd2);
        chk("t5_buffer", 34'(dct_buffer), 34'hD);
        chk("t5_ready", 34'(dct_ready), 34'd1);
        trace_en = 1'b1;
        pulse_flush();
        step(3);

        // 6: async reset with a held frame and partial buffer
        frm_ready = 1'b0;
        for (int i = 0; i < N; i++) send(2'b10);
        for (int i = 0; i < 7; i++) send(2'b01);
        chk("t6_pre_count", 34'(dct_count), 34'd7);
        chk("t6_pre_valid", 34'(frm_valid), 34'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_count", 34'(dct_count), 34'd0);
        chk("t6_buffer", 34'(dct_buffer), 34'd0);
        chk("t6_valid", 34'(frm_valid), 34'd0);
        chk("t6_data", frm_data, 34'd0);
        step(2);
        reset_n   = 1'b1;
        frm_ready = 1'b1;
        step(5);
        chk("t6_no_stale", 34'(frm_valid), 34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_1_oci_dct_packer.md
Name: cpu_1_oci_dct_packer

Overview:
- Upstream stage of the OCI direct-conditional-trace (DCT) path.
- Collects 2-bit conditional-branch outcome codes from the CPU trace port into a 30-bit packing buffer. It exposes the live buffer and occupancy as `dct_buffer` and `dct_count`, which feed the OCI test bench and monitor.
- Emits a packed frame to the downstream trace FIFO over a valid/ready handshake. It emits when the buffer is full or when a flush is requested.

Parameters:
- DCT_ENTRIES, 15, number of 2-bit entries per frame. Legal range 1..15. Buffer width is 2*DCT_ENTRIES, zero-padded to 30 bits.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- trace_en  in  1  when 0, incoming codes are discarded. `dct_ready` remains 1 in this state.
- dct_valid  in  1  code strobe from the CPU trace port.
- dct_code  in  2  01 = taken, 10 = not taken, 11 = exception/redirect, 00 = reserved (ignored).
- dct_ready  out  1  packer can take a code this cycle.
- flush  in  1  single-cycle request to emit a partial frame.
- dct_buffer  out  30  live packing buffer. Entry k occupies bits [2k+1:2k]; unused bits are 0.
- dct_count  out  4  live occupancy, 0..DCT_ENTRIES.
- frm_valid  out  1  frame register holds a frame.
- frm_ready  in  1  downstream FIFO accepts the frame.
- frm_data  out  34  {count[3:0], buffer[29:0]} captured at emit.

Behaviour:
- Reset (asynchronous): `dct_buffer`=0, `dct_count`=0, `frm_valid`=0, `frm_data`=0, flush_pend=0. After reset, `dct_ready`=1.
- `accept` = dct_valid & dct_ready & trace_en & (dct_code != 00). Reserved code 00 is dropped silently.
- `slot_free` = !frm_valid | frm_ready.
- `full` = (dct_count == DCT_ENTRIES).
- `emit` = slot_free & (full | (flush_pend & dct_count != 0)).
- `dct_ready` = !full | slot_free. This is combinational from `frm_valid`/`frm_ready`; there is no other combinational path.
- On accept without emit:
  - `dct_buffer[2*dct_count +: 2]` <= dct_code.
  - `dct_count` increments by 1.
- On emit:
  - `frm_data` <= {dct_count, dct_buffer}; `frm_valid` <= 1.
  - Buffer clears. If accept occurs in the same cycle, the new code lands at entry 0 and `dct_count`=1; otherwise `dct_count`=0 and the buffer is 0.
- Frame register handshake:
  - Holds stable while frm_valid & !frm_ready.
  - Cleared on frm_valid & frm_ready with no emit.
  - Reloaded when emit coincides with frm_ready (back-to-back frames, no bubble).
- Latency: the 15th accept at cycle N gives full at N+1. If the slot is free at N+1, emit occurs at N+1 and `frm_valid` rises at N+2.
- Flush:
  - `flush` sets flush_pend.
  - flush_pend clears on emit, or on any cycle where `dct_count`=0 and there is no accept. Flushing an empty buffer produces no frame.
  - If flush and accept occur in the same cycle, the accepted code is included in the flushed frame.
  - If a flush-triggered emit coincides with an accept, flush_pend clears and the new code starts the next frame.
- Backpressure: when full and the frame slot is blocked, `dct_ready`=0. Buffer and count hold, and no codes are lost.
- trace_en falling mid-frame: the partial buffer is retained and is emitted on the next full or flush condition.
- Reset asserted mid-operation: all state clears immediately, including any pending frame, which is discarded.
- `dct_count` never exceeds DCT_ENTRIES and never wraps.

Test Plan:
1. Reset, then 15 accepts of codes 01,10,11,01,... with frm_ready=1 -> `frm_valid` for 1 cycle. `frm_data[33:30]`=15 and `frm_data[1:0]`=01, `[3:2]`=10, `[5:4]`=11. `dct_count` returns to 0.
2. 3 accepts (01,01,10) then flush -> one frame with count=3, buffer=0x00000025. A second flush with an empty buffer produces no frame.
3. frm_ready=0, then 30 accepts -> the first frame is held. The buffer fills to 15 and `dct_ready`=0 with `dct_count` holding at 15. Raising frm_ready -> frame 1 accepted, frame 2 loaded the same cycle, and `dct_ready`=1.
4. Accept on the full-emit cycle -> frame carries count=15 and the new buffer has `dct_count`=1 with the new code at [1:0].
5. dct_code=00 and trace_en=0 strobes interleaved with valid codes -> these are ignored, `dct_count` advances only on valid codes, and `dct_ready` stays 1.
6. Assert reset_n=0 with `frm_valid`=1 and `dct_count`=7 -> all outputs are 0 asynchronously. After release, no stale frame appears.
